// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four BCD digits onto a common-anode display with
// leading-zero blanking and a per-frame snapshot so a frame never mixes old and new digits.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_idx
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    bcd_q, bcd_d, an_q, an_d;
  logic          dp_q, dp_d, run_q;
  logic          tick, load, z1, z2, z3, blank;
  logic [3:0]    nib;
  // run_q holds the count at 0 on the first enabled edge so the first slot is full length
  always_comb begin
    tick    = en && run_q && count_q == LAST;
    count_d = (en && run_q && !tick) ? count_q + CW'(1) : '0;
    idx_d   = en ? idx_q + {1'b0, tick} : 2'd0;
    load    = !en || (tick && idx_q == 2'd3);
    snap_d  = load ? digits : snap_q;
    sdp_d   = load ? dp_in : sdp_q;
    nib     = snap_d[{idx_d, 2'b00} +: 4];
    z3      = snap_d[15:12] == 4'h0;
    z2      = z3 && snap_d[11:8] == 4'h0;
    z1      = z2 && snap_d[7:4] == 4'h0;
    blank   = blank_lz && (idx_d == 2'd1 ? z1 : idx_d == 2'd2 ? z2 : idx_d == 2'd3 ? z3 : 1'b0);
    bcd_d   = (!en || blank) ? 4'hF : nib;
    an_d    = en ? ~(4'b0001 << idx_d) : 4'hF;
    dp_d    = en ? ~sdp_d[idx_d] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0;
      sdp_q   <= 4'h0;
      bcd_q   <= 4'hF;
      an_q    <= 4'hF;
      dp_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      sdp_q   <= sdp_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      run_q   <= en;
    end
  end
  assign bcd       = bcd_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed scan, blanking, snapshot, dp, reset and enable checks at REFRESH_DIV=4.
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd, an;
  logic        dp;
  logic [1:0]  digit_idx;
  int vectors = 0;
  int miscompares = 0;

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .bcd(bcd), .an(an), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] ae, input logic [3:0] be,
                     input logic de, input logic [1:0] ie);
    vectors++;
    assert (an === ae && bcd === be && dp === de && digit_idx === ie)
    else begin
      miscompares++;
      $error("FAIL %s: got an=%b bcd=%h dp=%b idx=%0d, want an=%b bcd=%h dp=%b idx=%0d",
             tag, an, bcd, dp, digit_idx, ae, be, de, ie);
    end
  endtask

  task automatic slot(input string tag, input int d, input logic [3:0] b, input logic de);
    logic [3:0] ae;
    ae = 4'hF;
    ae[d] = 1'b0;
    repeat (4) begin
      cyc();
      chk(tag, ae, b, de, 2'(d));
    end
  endtask

  task automatic frame(input string tag, input logic [3:0] b0, input logic [3:0] b1,
                       input logic [3:0] b2, input logic [3:0] b3, input logic [3:0] de);
    slot({tag, "_d0"}, 0, b0, de[0]);
    slot({tag, "_d1"}, 1, b1, de[1]);
    slot({tag, "_d2"}, 2, b2, de[2]);
    slot({tag, "_d3"}, 3, b3, de[3]);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 4'hF, 4'hF, 1'b1, 2'd0);
    cyc();
    rst_n = 1'b1;
    digits = 16'h1234;
    cyc();
    chk("disabled", 4'hF, 4'hF, 1'b1, 2'd0);
    en = 1'b1;
    frame("scan1234", 4'h4, 4'h3, 4'h2, 4'h1, 4'hF);
    slot("tear_d0", 0, 4'h4, 1'b1);
    slot("tear_d1", 1, 4'h3, 1'b1);
    digits = 16'h5678;
    slot("tear_d2", 2, 4'h2, 1'b1);
    slot("tear_d3", 3, 4'h1, 1'b1);
    frame("new5678", 4'h8, 4'h7, 4'h6, 4'h5, 4'hF);
    digits = 16'h0042;
    blank_lz = 1'b1;
    frame("lz0042", 4'h2, 4'h4, 4'hF, 4'hF, 4'hF);
    blank_lz = 1'b0;
    frame("nolz0042", 4'h2, 4'h4, 4'h0, 4'h0, 4'hF);
    digits = 16'h0000;
    blank_lz = 1'b1;
    frame("lz0000", 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    digits = 16'h0A00;
    frame("lz0A00", 4'h0, 4'h0, 4'hA, 4'hF, 4'hF);
    digits = 16'h1234;
    blank_lz = 1'b0;
    dp_in = 4'b0100;
    frame("dp2", 4'h4, 4'h3, 4'h2, 4'h1, 4'b1011);
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1 chk("reset_midslot", 4'hF, 4'hF, 1'b1, 2'd0);
    en = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    chk("post_reset_dis", 4'hF, 4'hF, 1'b1, 2'd0);
    en = 1'b1;
    slot("resume_d0", 0, 4'h4, 1'b1);
    cyc();
    chk("mid_d1a", 4'b1101, 4'h3, 1'b1, 2'd1);
    cyc();
    chk("mid_d1b", 4'b1101, 4'h3, 1'b1, 2'd1);
    en = 1'b0;
    cyc();
    chk("en_drop", 4'hF, 4'hF, 1'b1, 2'd0);
    en = 1'b1;
    slot("restart_d0", 0, 4'h4, 1'b1);
    slot("restart_d1", 1, 4'h3, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
